// File: rtl/sa_pkg.sv
// sa_pkg: shared defaults, column type and pointer-width helper for the result collector
package sa_pkg;
    localparam int COLS_DEF  = 8;
    localparam int MAC_W_DEF = 19;
    typedef logic [MAC_W_DEF-1:0] mac_t;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/sa_row_fifo.sv
// sa_row_fifo: first-word-fall-through row FIFO with registered output and synchronous clear
module sa_row_fifo
    import sa_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         wr_i,
    input  logic [W-1:0] wdata_i,
    input  logic         rdy_i,
    output logic [W-1:0] rdata_o,
    output logic         rvalid_o,
    output logic         full_o
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [W-1:0]  out_q, out_d;
    logic          v_q, v_d, rd;
    always_comb begin
        rd     = v_q & rdy_i;
        full_o = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
        mem_d  = mem_q;
        if (wr_i) mem_d[wp_q[AW-1:0]] = wdata_i;
        wp_d   = clr_i ? '0 : wp_q + PW'(wr_i);
        rp_d   = clr_i ? '0 : rp_q + PW'(rd);
        // head is judged against the pre-write pointer, so a fresh row shows one edge later
        v_d    = !clr_i && (rp_d != wp_q);
        out_d  = clr_i ? '0 : v_d ? mem_q[rp_d[AW-1:0]] : out_q;
    end
    always_ff @(posedge clk_i) mem_q <= mem_d;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            v_q   <= 1'b0;
            out_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            v_q   <= v_d;
            out_q <= out_d;
        end
    end
    assign rdata_o  = out_q;
    assign rvalid_o = v_q;
endmodule

// File: rtl/sa_result_collector.sv
// sa_result_collector: deskews systolic-array column results into rows and queues them downstream
module sa_result_collector
    import sa_pkg::*;
#(
    parameter int COLS  = COLS_DEF,
    parameter int MAC_W = MAC_W_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [COLS*MAC_W-1:0] mac_i,
    input  logic [COLS-1:0]       mac_v_i,
    input  logic                  clr_i,
    output logic [COLS*MAC_W-1:0] row_o,
    output logic                  row_v_o,
    input  logic                  row_rdy_i,
    output logic [CNT_W-1:0]      row_cnt_o,
    output logic [CNT_W-1:0]      drop_cnt_o,
    output logic                  ovf_o,
    output logic                  skew_err_o
);
    logic [COLS*MAC_W-1:0] arow;
    logic [COLS-1:0]       av;
    // column c waits COLS-1-c cycles so that every column lines up with the last one
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int N = COLS - 1 - c;
        if (N == 0) begin : g_pass
            assign arow[c*MAC_W +: MAC_W] = mac_i[c*MAC_W +: MAC_W];
            assign av[c]                  = mac_v_i[c];
        end else begin : g_dly
            logic [N-1:0][MAC_W-1:0] d_q, d_d;
            logic [N:0][MAC_W-1:0]   d_s;
            logic [N-1:0]            v_q, v_d;
            logic [N:0]              v_s;
            assign d_s = {d_q, mac_i[c*MAC_W +: MAC_W]};
            assign v_s = {v_q, mac_v_i[c]};
            always_comb begin
                v_d = v_s[N-1:0];
                for (int k = 0; k < N; k++) d_d[k] = v_s[k] ? d_s[k] : d_q[k];
            end
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    d_q <= '0;
                    v_q <= '0;
                end else begin
                    d_q <= d_d;
                    v_q <= v_d;
                end
            end
            assign arow[c*MAC_W +: MAC_W] = d_q[N-1];
            assign av[c]                  = v_q[N-1];
        end
    end
    logic             all_v, rd, wr, drop, full;
    logic [CNT_W-1:0] row_cnt_q, row_cnt_d, drop_cnt_q, drop_cnt_d;
    logic             ovf_q, ovf_d, skew_q, skew_d;
    always_comb begin
        all_v      = &av;
        rd         = row_v_o & row_rdy_i;
        wr         = all_v & (~full | rd) & ~clr_i;
        drop       = all_v & full & ~rd & ~clr_i;
        row_cnt_d  = clr_i ? '0 : row_cnt_q + CNT_W'(wr);
        drop_cnt_d = clr_i ? '0 : (drop && !(&drop_cnt_q)) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
        ovf_d      = ~clr_i & (ovf_q | drop);
        skew_d     = ~clr_i & (skew_q | (~all_v & (|av)));
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            skew_q     <= 1'b0;
        end else begin
            row_cnt_q  <= row_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
            skew_q     <= skew_d;
        end
    end
    sa_row_fifo #(.W(COLS*MAC_W), .DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr_i),
        .wr_i    (wr),
        .wdata_i (arow),
        .rdy_i   (row_rdy_i),
        .rdata_o (row_o),
        .rvalid_o(row_v_o),
        .full_o  (full)
    );
    assign row_cnt_o  = row_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
    assign ovf_o      = ovf_q;
    assign skew_err_o = skew_q;
endmodule
